// File: rtl/fpu_regfile_pkg.sv
// fpu_regfile_pkg: shared types and helpers for the FPU register file.
// State enum, default geometry, and the winning-writer selector.
package fpu_regfile_pkg;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  localparam int DEF_DATA_W = 36;
  localparam int DEF_DEPTH  = 512;
  localparam int MAX_PORTS  = 4;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } win_t;

  // match[j]: write port j targets the address of interest.
  // The highest matching port index wins.
  function automatic win_t win_sel(
    input logic [MAX_PORTS-1:0] match
  );
    win_t w;
    w = '0;
    for (int j = 0; j < MAX_PORTS; j++) begin
      if (match[j]) begin
        w.hit = 1'b1;
        w.idx = 2'(j);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/fpu_regfile_scoreboard.sv
// fpu_regfile_scoreboard: per-entry busy bits and their population count.
// In: set_en/set_addr, clr_en/clr_addr (NCLR ports), clr_all, rd_addr. Out: rd_busy (post-update), busy_cnt.
module fpu_regfile_scoreboard
  import fpu_regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int NRD   = 2,
  parameter int NCLR  = 3,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic [NCLR-1:0]   clr_en,
  input  logic [NCLR*AW-1:0] clr_addr,
  input  logic              clr_all,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  output logic [AW:0]       busy_cnt
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic [AW:0]      falls;
  logic             rise;
  logic             dup;

  // Clears first, then the set so a reservation beats a write.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NCLR; j++) begin
      if (clr_en[j]) busy_d[clr_addr[j*AW +: AW]] = 1'b0;
    end
    if (set_en) busy_d[set_addr] = 1'b1;
    if (clr_all) busy_d = '0;
  end

  // Count each distinct entry leaving the busy state once.
  always_comb begin
    rise  = set_en && !busy_q[set_addr];
    falls = '0;
    dup   = 1'b0;
    for (int j = 0; j < NCLR; j++) begin
      dup = 1'b0;
      for (int k = 0; k < j; k++) begin
        if (clr_en[k] &&
            clr_addr[k*AW +: AW] == clr_addr[j*AW +: AW])
          dup = 1'b1;
      end
      if (clr_en[j] && !dup &&
          busy_q[clr_addr[j*AW +: AW]] &&
          !(set_en && set_addr == clr_addr[j*AW +: AW]))
        falls = falls + (AW+1)'(1);
    end
    if (clr_all) cnt_d = '0;
    else cnt_d = cnt_q + (AW+1)'(rise) - falls;
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_busy[i] = busy_d[rd_addr[i*AW +: AW]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;

endmodule

// File: rtl/fpu_regfile_mp.sv
// fpu_regfile_mp: multi-port FPU register file with clear sequencer and busy scoreboard.
// Ports: clk, rst_n, init_req/init_done, rd_* (NRD), wr_* (NWR), rsv_*, busy_cnt. Macro FPU_REGFILE_BYPASS_EN: write-first reads.
module fpu_regfile_mp
  import fpu_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_valid,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*AW-1:0]     wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  output logic [AW:0]           busy_cnt
);

  localparam int NCLR = NWR + 1;

  state_e          state_q;
  state_e          state_d;
  logic [AW-1:0]   clr_q;
  logic [AW-1:0]   clr_d;
  logic            ready;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_nxt [NRD];
  logic [NRD-1:0]    sb_busy;

  assign ready     = (state_q == ST_READY);
  assign init_done = ready;

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    unique case (state_q)
      ST_INIT: begin
        clr_d = clr_q + AW'(1);
        if (clr_q == AW'(DEPTH-1)) state_d = ST_READY;
      end
      ST_READY: begin
        if (init_req) begin
          state_d = ST_INIT;
          clr_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // Later ports overwrite earlier ones, so the highest index wins.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[clr_q] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j])
          mem[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

`ifdef FPU_REGFILE_BYPASS_EN
  logic [MAX_PORTS-1:0] match;
  win_t                 win;

  always_comb begin
    match = '0;
    win   = '0;
    for (int i = 0; i < NRD; i++) begin
      match = '0;
      for (int j = 0; j < NWR; j++) begin
        match[j] = wr_en[j] &&
                   (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW]);
      end
      win = win_sel(match);
      if (win.hit)
        rd_nxt[i] = wr_data[int'(win.idx)*DATA_W +: DATA_W];
      else
        rd_nxt[i] = mem[rd_addr[i*AW +: AW]];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_nxt[i] = mem[rd_addr[i*AW +: AW]];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= '0;
      rd_busy  <= '0;
    end else if (ready) begin
      rd_valid <= rd_en;
      for (int i = 0; i < NRD; i++) begin
        if (rd_en[i]) begin
          rd_data[i*DATA_W +: DATA_W] <= rd_nxt[i];
          rd_busy[i]                  <= sb_busy[i];
        end
      end
    end else begin
      rd_valid <= '0;
    end
  end

  fpu_regfile_scoreboard #(
    .DEPTH (DEPTH),
    .NRD   (NRD),
    .NCLR  (NCLR),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (rsv_en & ready),
    .set_addr (rsv_addr),
    .clr_en   ({~ready, wr_en & {NWR{ready}}}),
    .clr_addr ({clr_q, wr_addr}),
    .clr_all  (init_req & ready),
    .rd_addr  (rd_addr),
    .rd_busy  (sb_busy),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_fpu_regfile_mp.sv
// tb_fpu_regfile_mp: randomized and directed checks against a behavioural model.
// Build with or without FPU_REGFILE_BYPASS_EN; expectations follow the macro.
module tb_fpu_regfile_mp;

  localparam int DW    = 36;
  localparam int DEPTH = 64;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              init_req;
  logic              init_done;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_valid;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic [AW:0]       busy_cnt;

  fpu_regfile_mp #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .NRD    (NRD),
    .NWR    (NWR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_req  (init_req),
    .init_done (init_done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;

  // reference model
  logic [DW-1:0]  m_mem [DEPTH];
  bit             m_busy [DEPTH];
  bit             m_ready;
  int             m_clr;
  logic [DW-1:0]  e_data [NRD];
  logic [NRD-1:0] e_valid;
  logic [NRD-1:0] e_busy;

  int total = 0;
  int bad   = 0;

  function automatic int pop();
    int n = 0;
    for (int e = 0; e < DEPTH; e++) n += int'(m_busy[e]);
    return n;
  endfunction

  task automatic idle();
    init_req = 1'b0;
    rd_en    = '0;
    rd_addr  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_clr   = 0;
    for (int e = 0; e < DEPTH; e++) m_busy[e] = 1'b0;
    for (int i = 0; i < NRD; i++) e_data[i] = '0;
    e_valid = '0;
    e_busy  = '0;
  endtask

  task automatic model_step();
    logic [DW-1:0] rv [NRD];
    if (!m_ready) begin
      m_mem[m_clr]  = '0;
      m_busy[m_clr] = 1'b0;
      e_valid = '0;
      m_clr++;
      if (m_clr == DEPTH) m_ready = 1'b1;
      return;
    end
    for (int i = 0; i < NRD; i++) begin
      rv[i] = m_mem[rd_addr[i*AW +: AW]];
`ifdef FPU_REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])
          rv[i] = wr_data[j*DW +: DW];
`endif
    end
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j]) begin
        m_mem[wr_addr[j*AW +: AW]]  = wr_data[j*DW +: DW];
        m_busy[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_en) m_busy[rsv_addr] = 1'b1;
    if (init_req) begin
      for (int e = 0; e < DEPTH; e++) m_busy[e] = 1'b0;
      m_ready = 1'b0;
      m_clr   = 0;
    end
    for (int i = 0; i < NRD; i++) begin
      e_valid[i] = rd_en[i];
      if (rd_en[i]) begin
        e_data[i] = rv[i];
        e_busy[i] = m_busy[rd_addr[i*AW +: AW]];
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (init_done !== 1'b0) begin
      bad++; $display("FAIL reset_init_done: got %b want 0", init_done);
    end
    total++;
    if (rd_valid !== '0) begin
      bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid);
    end
    total++;
    if (rd_busy !== '0) begin
      bad++; $display("FAIL reset_rd_busy: got %b want 0", rd_busy);
    end
    total++;
    if (busy_cnt !== '0) begin
      bad++; $display("FAIL reset_busy_cnt: got %0d want 0", busy_cnt);
    end
    total++;
    if (rd_data !== '0) begin
      bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_init_timing(input string tag);
    int n = 0;
    while (init_done !== 1'b1 && n < DEPTH + 8) begin
      step();
      n++;
    end
    total++;
    if (init_done !== 1'b1 || n != DEPTH) begin
      bad++;
      $display("FAIL %s_init_cycles: got %0d edges (done=%b) want %0d",
               tag, n, init_done, DEPTH);
    end
  endtask

  task automatic test_read_all_zero(input string tag);
    for (int a = 0; a < DEPTH; a += 2) begin
      idle();
      rd_en = 2'b11;
      rd_addr[0 +: AW]  = AW'(a);
      rd_addr[AW +: AW] = AW'(a + 1);
      step();
      total++;
      if (rd_data !== '0 || rd_valid !== 2'b11 || rd_busy !== 2'b00) begin
        bad++;
        $display("FAIL %s_zero a=%0d: got data=%h v=%b b=%b want 0/11/00",
                 tag, a, rd_data, rd_valid, rd_busy);
      end
    end
    idle();
    total++;
    if (busy_cnt !== '0) begin
      bad++; $display("FAIL %s_cnt: got %0d want 0", tag, busy_cnt);
    end
  endtask

  task automatic test_write_read();
    idle();
    wr_en = 2'b01;
    wr_addr[0 +: AW] = AW'(5);
    wr_data[0 +: DW] = 36'h123456789;
    step();
    idle();
    rd_en = 2'b11;
    rd_addr = {AW'(5), AW'(5)};
    step();
    total++;
    if (rd_data !== {36'h123456789, 36'h123456789} || rd_valid !== 2'b11) begin
      bad++;
      $display("FAIL write_read: got %h v=%b want 123456789 x2 v=11",
               rd_data, rd_valid);
    end
    idle();
    step();
    total++;
    if (rd_valid !== 2'b00 || rd_data[0 +: DW] !== 36'h123456789) begin
      bad++;
      $display("FAIL read_hold: got v=%b d=%h want v=00 d=123456789",
               rd_valid, rd_data[0 +: DW]);
    end
  endtask

  task automatic test_same_addr_write();
    idle();
    wr_en   = 2'b11;
    wr_addr = {AW'(7), AW'(7)};
    wr_data = {36'hB, 36'hA};
    step();
    idle();
    rd_en = 2'b01;
    rd_addr[0 +: AW] = AW'(7);
    step();
    total++;
    if (rd_data[0 +: DW] !== 36'hB) begin
      bad++;
      $display("FAIL multi_write: got %h want b", rd_data[0 +: DW]);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
`ifdef FPU_REGFILE_BYPASS_EN
    want = 36'hC;
`else
    want = 36'h0;
`endif
    idle();
    wr_en = 2'b01;
    wr_addr[0 +: AW] = AW'(9);
    wr_data[0 +: DW] = 36'hC;
    rd_en = 2'b01;
    rd_addr[0 +: AW] = AW'(9);
    step();
    total++;
    if (rd_data[0 +: DW] !== want) begin
      bad++;
      $display("FAIL same_cycle_rw: got %h want %h", rd_data[0 +: DW], want);
    end
    idle();
    rd_en = 2'b10;
    rd_addr[AW +: AW] = AW'(9);
    step();
    total++;
    if (rd_data[DW +: DW] !== 36'hC) begin
      bad++;
      $display("FAIL after_rw: got %h want c", rd_data[DW +: DW]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    rsv_en = 1'b1; rsv_addr = AW'(3);
    step();
    rsv_addr = AW'(4);
    step();
    idle();
    total++;
    if (busy_cnt !== (AW+1)'(2)) begin
      bad++; $display("FAIL rsv_cnt2: got %0d want 2", busy_cnt);
    end
    wr_en = 2'b01;
    wr_addr[0 +: AW] = AW'(3);
    wr_data[0 +: DW] = 36'h33;
    step();
    idle();
    total++;
    if (busy_cnt !== (AW+1)'(1)) begin
      bad++; $display("FAIL wr_clear_cnt: got %0d want 1", busy_cnt);
    end
    wr_en = 2'b10;
    wr_addr[AW +: AW] = AW'(4);
    wr_data[DW +: DW] = 36'h44;
    rsv_en = 1'b1; rsv_addr = AW'(4);
    step();
    idle();
    total++;
    if (busy_cnt !== (AW+1)'(1)) begin
      bad++; $display("FAIL rsv_wins_cnt: got %0d want 1", busy_cnt);
    end
    rd_en = 2'b11;
    rd_addr = {AW'(3), AW'(4)};
    step();
    idle();
    total++;
    if (rd_busy !== 2'b01 || rd_data !== {36'h33, 36'h44}) begin
      bad++;
      $display("FAIL rsv_wins_rd: got b=%b d=%h want b=01 d=33/44",
               rd_busy, rd_data);
    end
  endtask

  task automatic test_random(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      idle();
      rd_en = NRD'($urandom);
      for (int i = 0; i < NRD; i++)
        rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
      wr_en = NWR'($urandom);
      for (int j = 0; j < NWR; j++) begin
        wr_addr[j*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[j*DW +: DW] = DW'({$urandom(), $urandom()});
      end
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = AW'($urandom_range(0, 9));
      init_req = ($urandom_range(0, 149) == 0);
      step();
      total++;
      if (init_done !== m_ready || busy_cnt !== (AW+1)'(pop())) begin
        bad++;
        $display("FAIL rnd_state c=%0d: got done=%b cnt=%0d want %b/%0d",
                 c, init_done, busy_cnt, m_ready, pop());
      end
      total++;
      if (rd_valid !== e_valid || rd_busy !== e_busy) begin
        bad++;
        $display("FAIL rnd_flags c=%0d: got v=%b b=%b want v=%b b=%b",
                 c, rd_valid, rd_busy, e_valid, e_busy);
      end
      for (int i = 0; i < NRD; i++) begin
        total++;
        if (rd_data[i*DW +: DW] !== e_data[i]) begin
          bad++;
          $display("FAIL rnd_data c=%0d p=%0d: got %h want %h",
                   c, i, rd_data[i*DW +: DW], e_data[i]);
        end
      end
    end
    idle();
  endtask

  task automatic test_reinit();
    int n = 0;
    idle();
    while (!m_ready && n < DEPTH + 8) begin
      step(); n++;
    end
    wr_en = 2'b01;
    wr_addr[0 +: AW] = AW'(10);
    wr_data[0 +: DW] = 36'hFACE;
    rsv_en = 1'b1; rsv_addr = AW'(11);
    step();
    idle();
    rsv_en = 1'b1; rsv_addr = AW'(12);
    step();
    idle();
    init_req = 1'b1;
    step();
    total++;
    if (init_done !== 1'b0 || busy_cnt !== '0) begin
      bad++;
      $display("FAIL reinit_start: got done=%b cnt=%0d want 0/0",
               init_done, busy_cnt);
    end
    n = 0;
    while (init_done !== 1'b1 && n < DEPTH + 8) begin
      idle();
      wr_en   = 2'b11;
      wr_addr = {AW'($urandom_range(0, DEPTH-1)), AW'(n % DEPTH)};
      wr_data = {36'h5A5, 36'hBAD};
      rsv_en  = 1'b1;
      rsv_addr = AW'($urandom_range(0, DEPTH-1));
      init_req = 1'b1;
      rd_en = 2'b11;
      step();
      total++;
      if (rd_valid !== 2'b00) begin
        bad++; $display("FAIL reinit_valid n=%0d: got %b want 00", n, rd_valid);
      end
      n++;
    end
    total++;
    if (n != DEPTH) begin
      bad++; $display("FAIL reinit_cycles: got %0d want %0d", n, DEPTH);
    end
    idle();
    test_read_all_zero("reinit");
  endtask

  task automatic test_async_reset();
    idle();
    rsv_en = 1'b1; rsv_addr = AW'(20);
    step();
    idle();
    rd_en = 2'b01;
    rd_addr[0 +: AW] = AW'(20);
    step();
    idle();
    rst_n = 1'b0;
    #1;
    total++;
    if (busy_cnt !== '0 || rd_valid !== '0 || rd_busy !== '0 ||
        init_done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got cnt=%0d v=%b b=%b done=%b want 0",
               busy_cnt, rd_valid, rd_busy, init_done);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_init_timing("rst2");
  endtask

  initial begin
    test_reset();
    test_init_timing("rst");
    test_read_all_zero("init");
    test_write_read();
    test_same_addr_write();
    test_bypass();
    test_scoreboard();
    test_random(600);
    test_reinit();
    test_async_reset();
    test_random(200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
